// File: rtl/read_resp_pkg.sv
// Shared types and constants for the read_responder block.
package read_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } resp_state_t;

    localparam int unsigned LAT_W = 4;

endpackage

// File: rtl/read_responder_mem.sv
// DEPTH x WIDTH register file: synchronous write, asynchronous read.
module resp_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/read_responder.sv
// Target side of the rd/ds read handshake; returns store words LATENCY cycles after ds.
// Optional feature: define RESP_PARITY_EN to add the registered rpar output.
module read_responder
    import read_resp_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd,
    input  logic                     ds,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    output logic                     busy,
    output logic                     err
`ifdef RESP_PARITY_EN
    ,
    output logic                     rpar
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

    resp_state_t      r_state;
    resp_state_t      w_next;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_cnt_next;
    logic [AW-1:0]    r_rptr;
    logic             r_err;
    logic             w_err_set;
    logic             w_capture;
    logic [WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0] w_mem_rd;

    resp_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk     (clk),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_rptr),
        .o_rd_data (w_mem_rd)
    );

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_err_set  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (rd) begin
                    w_next = ARMED;
                end else if (ds) begin
                    w_err_set = 1'b1;
                end
            end
            ARMED: begin
                if (!rd) begin
                    w_next = IDLE;
                end else if (ds) begin
                    if (LATENCY == 0) begin
                        w_next = RESP;
                    end else begin
                        w_next     = WAIT;
                        w_cnt_next = LAT_M1;
                    end
                end
            end
            WAIT: begin
                w_err_set = ds;
                if (r_cnt == '0) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            RESP: begin
                w_err_set = ds;
                w_next    = rd ? ARMED : IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Capture uses the pre-edge async read, so a same-cycle write to mem[rptr] yields the old word.
        w_capture = (w_next == RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rptr  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (r_state == RESP) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_capture) begin
                r_rdata <= w_mem_rd;
            end
        end
    end

`ifdef RESP_PARITY_EN
    logic r_rpar;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rpar <= 1'b0;
        end else if (w_capture) begin
            r_rpar <= ^w_mem_rd;
        end
    end

    assign rpar = r_rpar;
`endif

    assign rdata  = r_rdata;
    assign rvalid = (r_state == RESP);
    assign busy   = (r_state != IDLE);
    assign err    = r_err;

endmodule

// File: tb/tb_read_responder.sv
// Directed self-checking bench for read_responder (LATENCY=2 and LATENCY=0 instances).
module tb_read_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd, ds, rd1, ds1;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rdata, rdata1;
    logic       rvalid, busy, err, rvalid1, busy1, err1;
`ifdef RESP_PARITY_EN
    logic       rpar, rpar1;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    read_responder #(.WIDTH(8), .DEPTH(16), .LATENCY(2)) u0 (
        .clk(clk), .rst(rst), .rd(rd), .ds(ds),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rdata(rdata), .rvalid(rvalid), .busy(busy), .err(err)
`ifdef RESP_PARITY_EN
        , .rpar(rpar)
`endif
    );

    read_responder #(.WIDTH(8), .DEPTH(16), .LATENCY(0)) u1 (
        .clk(clk), .rst(rst), .rd(rd1), .ds(ds1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rdata(rdata1), .rvalid(rvalid1), .busy(busy1), .err(err1)
`ifdef RESP_PARITY_EN
        , .rpar(rpar1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // One ds pulse from ARMED on u0; response expected on the third following negedge.
    task automatic request(input string tag, input logic [7:0] exp);
        ds = 1'b1;
        tick();
        ds = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_rv_n1"}, rvalid, 0);
        tick();
        check({tag, "_rv_n2"}, rvalid, 0);
        tick();
        check({tag, "_rv"}, rvalid, 1);
        check({tag, "_data"}, rdata, exp);
        tick();
        check({tag, "_rv_off"}, rvalid, 0);
    endtask

    initial begin
        rst = 1'b0; rd = 1'b0; ds = 1'b0; rd1 = 1'b0; ds1 = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick();
        tick();
        check("rst_rdata", rdata, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_busy1", busy1, 0);
        rst = 1'b1;

        write_mem(4'd0, 8'hA5);
        write_mem(4'd1, 8'h3C);
        for (int i = 2; i < 16; i++) write_mem(4'(i), 8'(8'h40 + i));

        // basic reads
        rd = 1'b1;
        tick();
        check("armed_busy", busy, 1);
        request("t1_w0", 8'hA5);
        request("t1_w1", 8'h3C);

        // pointer wrap
        for (int i = 2; i < 16; i++) request("t2_seq", 8'(8'h40 + i));
        request("t2_wrap0", 8'hA5);
        request("t2_wrap1", 8'h3C);

        // ds in IDLE
        rd = 1'b0;
        tick();
        check("t3_idle_busy", busy, 0);
        ds = 1'b1;
        tick();
        ds = 1'b0;
        check("t3_idle_err", err, 1);
        check("t3_idle_rv", rvalid, 0);
        tick();
        check("t3_idle_rv2", rvalid, 0);

        // overrun ds in WAIT
        rst = 1'b0;
        tick();
        check("t3_rst_err", err, 0);
        rst = 1'b1;
        rd  = 1'b1;
        tick();
        ds = 1'b1;
        tick();
        tick();
        ds = 1'b0;
        check("t3_ovr_err", err, 1);
        check("t3_ovr_rv0", rvalid, 0);
        tick();
        check("t3_ovr_rv", rvalid, 1);
        check("t3_ovr_data", rdata, 8'hA5);
        tick();
        check("t3_ovr_rv_off", rvalid, 0);
        tick();
        check("t3_ovr_single", rvalid, 0);

        // rd dropped during WAIT
        ds = 1'b1;
        tick();
        ds = 1'b0;
        rd = 1'b0;
        tick();
        check("t4_rv0", rvalid, 0);
        tick();
        check("t4_rv", rvalid, 1);
        check("t4_data", rdata, 8'h3C);
        tick();
        check("t4_busy", busy, 0);
        check("t4_rv_off", rvalid, 0);

        // reset during WAIT
        rd = 1'b1;
        tick();
        ds = 1'b1;
        tick();
        ds = 1'b0;
        check("t5_inwait", busy, 1);
        rst = 1'b0;
        #1;
        check("t5_rv", rvalid, 0);
        check("t5_rdata", rdata, 0);
        check("t5_err", err, 0);
        check("t5_busy", busy, 0);
        tick();
        check("t5_rv_a", rvalid, 0);
        tick();
        check("t5_rv_b", rvalid, 0);
        rst = 1'b1;
        tick();
        request("t5_after", 8'hA5);

        // zero latency instance
        write_mem(4'd0, 8'h07);
        rd1 = 1'b1;
        tick();
        ds1 = 1'b1;
        tick();
        ds1 = 1'b0;
        check("t6_rv", rvalid1, 1);
        check("t6_data", rdata1, 8'h07);
`ifdef RESP_PARITY_EN
        check("t6_rpar", rpar1, 1);
`endif
        tick();
        check("t6_rv_off", rvalid1, 0);
        // write to mem[rptr] in the capture cycle returns the old word
        ds1     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd1;
        wr_data = 8'hEE;
        tick();
        ds1   = 1'b0;
        wr_en = 1'b0;
        check("t6_old_rv", rvalid1, 1);
        check("t6_old_data", rdata1, 8'h3C);
`ifdef RESP_PARITY_EN
        check("t6_old_rpar", rpar1, 0);
`endif
        tick();
        check("t6_err1", err1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
